// File: rtl/oflow_gate_gen_if.sv
// Bundle of trigger/config inputs, raw ADC overflow flags and gate/overflow
// outputs shared between oflow_gate_gen (slave) and its driver (master).
interface oflow_gate_gen_if #(
    parameter int NCH   = 2,
    parameter int CNT_W = 8
);
    logic             trig;
    logic [CNT_W-1:0] delay;
    logic [CNT_W-1:0] width;
    logic [NCH-1:0]   adc_oflow_raw;
    logic             gate;
    logic             oflow_out;
    logic [NCH-1:0]   oflow_ch;
    logic             busy;

    modport master (
        output trig, delay, width, adc_oflow_raw,
        input  gate, oflow_out, oflow_ch, busy
    );

    modport slave (
        input  trig, delay, width, adc_oflow_raw,
        output gate, oflow_out, oflow_ch, busy
    );
endinterface

// File: rtl/oflow_gate_gen.sv
// oflow_gate_gen: trigger-driven measurement window generator with
// per-channel sticky ADC overflow capture.
//
// A rising trig edge seen while idle starts a window: wait `delay` cycles,
// hold gate high for `width` cycles, then ignore triggers for HOLDOFF cycles.
// Compile-time option OFLOW_DEBOUNCE_EN: when defined, an overflow must be
// present two consecutive cycles before it is reported (oflow_out and
// oflow_ch); otherwise the raw flags are used directly.
module oflow_gate_gen #(
    parameter int NCH     = 2,
    parameter int CNT_W   = 8,
    parameter int HOLDOFF = 16
) (
    input  logic           clk,
    input  logic           rst,
    oflow_gate_gen_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_OPEN  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLDOFF);
    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count down towards zero and stay there; the counter never wraps.
    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - ONE;
    endfunction

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] width_lat;
    logic             load_w;

    logic             trig_q;
    logic             armed;
    logic             trig_edge;

    logic             gate_r;
    logic             busy_r;
    logic             oflow_r;
    logic [NCH-1:0]   oflow_ch_r;
    logic [NCH-1:0]   qual;
    logic             oflow_nx;

    // armed stays low while trig has been high continuously since reset, so a
    // trig held across reset release never looks like a fresh edge.
    assign trig_edge = bus.trig & ~trig_q & armed;

`ifdef OFLOW_DEBOUNCE_EN
    logic [NCH-1:0] raw_q;
    logic           any_q;

    // Remember last cycle's raw flags for the two-cycle qualification.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q <= '0;
            any_q <= 1'b0;
        end else begin
            raw_q <= bus.adc_oflow_raw;
            any_q <= |bus.adc_oflow_raw;
        end
    end

    assign qual     = bus.adc_oflow_raw & raw_q;
    assign oflow_nx = (|bus.adc_oflow_raw) & any_q;
`else
    assign qual     = bus.adc_oflow_raw;
    assign oflow_nx = |bus.adc_oflow_raw;
`endif

    // Next-state and counter reload for the IDLE/DELAY/OPEN/HOLD sequence.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        load_w   = 1'b0;
        case (state)
            S_IDLE: begin
                if (trig_edge) begin
                    load_w = 1'b1;
                    if (bus.delay != '0) begin
                        state_nx = S_DELAY;
                        cnt_nx   = bus.delay;
                    end else if (bus.width != '0) begin
                        state_nx = S_OPEN;
                        cnt_nx   = bus.width;
                    end else begin
                        state_nx = S_HOLD;
                        cnt_nx   = HOLD_LD;
                    end
                end
            end
            S_DELAY: begin
                if (cnt > ONE) begin
                    cnt_nx = dec_sat(cnt);
                end else if (width_lat != '0) begin
                    state_nx = S_OPEN;
                    cnt_nx   = width_lat;
                end else begin
                    state_nx = S_HOLD;
                    cnt_nx   = HOLD_LD;
                end
            end
            S_OPEN: begin
                if (cnt > ONE) begin
                    cnt_nx = dec_sat(cnt);
                end else begin
                    state_nx = S_HOLD;
                    cnt_nx   = HOLD_LD;
                end
            end
            S_HOLD: begin
                // A zero holdoff still spends one cycle here.
                if (cnt > ONE) begin
                    cnt_nx = dec_sat(cnt);
                end else begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Width is captured at the trigger edge so later input changes do not
    // disturb a window already in flight.
    always_ff @(posedge clk) begin
        if (load_w) width_lat <= bus.width;
    end

    // State, counters, edge detector and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            trig_q     <= 1'b0;
            armed      <= ~bus.trig;
            gate_r     <= 1'b0;
            busy_r     <= 1'b0;
            oflow_r    <= 1'b0;
            oflow_ch_r <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            trig_q  <= bus.trig;
            armed   <= armed | ~bus.trig;
            gate_r  <= (state_nx == S_OPEN);
            busy_r  <= (state_nx != S_IDLE);
            oflow_r <= oflow_nx;
            if (state_nx == S_OPEN && state != S_OPEN) begin
                oflow_ch_r <= '0;
            end else if (gate_r) begin
                oflow_ch_r <= oflow_ch_r | qual;
            end
        end
    end

    assign bus.gate      = gate_r;
    assign bus.busy      = busy_r;
    assign bus.oflow_out = oflow_r;
    assign bus.oflow_ch  = oflow_ch_r;

endmodule

// File: tb/tb_oflow_gate_gen.sv
// Scoreboard bench for oflow_gate_gen: a window-schedule reference model
// predicts each cycle's outputs, a separate monitor compares them.
module tb_oflow_gate_gen;
    localparam int NCH     = 2;
    localparam int CNT_W   = 8;
    localparam int HOLDOFF = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oflow_gate_gen_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

    oflow_gate_gen #(.NCH(NCH), .CNT_W(CNT_W), .HOLDOFF(HOLDOFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int             cyc;
        logic           gate;
        logic           busy;
        logic           oflow_out;
        logic [NCH-1:0] oflow_ch;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: one window described by its cycle boundaries.
    bit             m_prev_trig = 1'b0;
    bit             m_have = 1'b0;
    int             m_ts, m_os, m_oe, m_be, m_w;
    bit [NCH-1:0]   m_ch = '0;
    bit             m_prev_any = 1'b0;
    bit [NCH-1:0]   m_prev_raw = '0;

    function automatic bit m_gate(input int c);
        return m_have && (m_w > 0) && (c >= m_os) && (c <= m_oe);
    endfunction

    function automatic bit m_busy(input int c);
        return m_have && (c >= m_ts + 1) && (c <= m_be);
    endfunction

    task automatic step(input bit r, input bit t, input int d, input int w,
                        input bit [NCH-1:0] raw);
        int k;
        exp_t e;
        bit g_now;
        bit oflow;
        bit [NCH-1:0] q;
        @(posedge clk);
        #1;
        k = cyc;
        rst               = r;
        bus.trig          = t;
        bus.delay         = CNT_W'(d);
        bus.width         = CNT_W'(w);
        bus.adc_oflow_raw = raw;
`ifdef OFLOW_DEBOUNCE_EN
        q     = raw & m_prev_raw;
        oflow = (|raw) && m_prev_any;
`else
        q     = raw;
        oflow = |raw;
`endif
        g_now = m_gate(k);
        if (r) begin
            m_have     = 1'b0;
            m_ch       = '0;
            oflow      = 1'b0;
            m_prev_any = 1'b0;
            m_prev_raw = '0;
        end else begin
            if (t && !m_prev_trig && !m_busy(k)) begin
                m_have = 1'b1;
                m_ts   = k;
                m_w    = w;
                m_os   = k + d + 1;
                m_oe   = m_os + w - 1;
                m_be   = k + d + w + ((HOLDOFF == 0) ? 1 : HOLDOFF);
            end
            if (m_gate(k + 1) && !g_now) m_ch = '0;
            else if (g_now)              m_ch = m_ch | q;
            m_prev_any = |raw;
            m_prev_raw = raw;
        end
        m_prev_trig = t;
        e.cyc       = k + 1;
        e.gate      = m_gate(k + 1);
        e.busy      = m_busy(k + 1);
        e.oflow_out = oflow;
        e.oflow_ch  = m_ch;
        sbq.push_back(e);
    endtask

    task automatic run(input int n, input bit t, input int d, input int w,
                       input bit [NCH-1:0] raw);
        for (int i = 0; i < n; i++) step(1'b0, t, d, w, raw);
    endtask

    // Monitor: compare DUT outputs against the expectation for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missed_cycle: expectation for cycle %0d never checked (now %0d)", e.cyc, cyc);
            end
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                n_vec++;
                if (bus.gate !== e.gate || bus.busy !== e.busy ||
                    bus.oflow_out !== e.oflow_out || bus.oflow_ch !== e.oflow_ch) begin
                    n_err++;
                    $display("FAIL outputs cyc %0d: got gate=%b busy=%b oflow_out=%b oflow_ch=%b, want gate=%b busy=%b oflow_out=%b oflow_ch=%b",
                             cyc, bus.gate, bus.busy, bus.oflow_out, bus.oflow_ch,
                             e.gate, e.busy, e.oflow_out, e.oflow_ch);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized run.
    initial begin
        bit t;
        int d, w;
        bit [NCH-1:0] raw;
        bus.trig          = 1'b0;
        bus.delay         = '0;
        bus.width         = '0;
        bus.adc_oflow_raw = '0;

        step(1'b1, 1'b0, 0, 0, 2'b00);
        step(1'b1, 1'b0, 0, 0, 2'b00);
        run(5, 1'b0, 0, 0, 2'b00);

        // delay=3 width=5, inputs changed while busy
        step(1'b0, 1'b1, 3, 5, 2'b00);
        run(3, 1'b1, 7, 9, 2'b00);
        run(35, 1'b0, 1, 1, 2'b00);

        // delay=0 width=0: HOLD only
        step(1'b0, 1'b1, 0, 0, 2'b00);
        run(22, 1'b0, 0, 0, 2'b00);

        // repeated edges during OPEN and HOLD, then a fresh window
        step(1'b0, 1'b1, 2, 6, 2'b00);
        for (int i = 1; i < 60; i++) step(1'b0, i[1], 2, 6, 2'b00);
        run(30, 1'b0, 0, 0, 2'b00);

        // single-cycle overflow on channel 1 inside the window
        step(1'b0, 1'b1, 1, 6, 2'b00);
        run(3, 1'b0, 1, 6, 2'b00);
        step(1'b0, 1'b0, 1, 6, 2'b10);
        run(30, 1'b0, 1, 6, 2'b00);
        step(1'b0, 1'b1, 0, 3, 2'b00);
        run(25, 1'b0, 0, 3, 2'b00);

        // overflow outside any window reaches oflow_out only
        step(1'b0, 1'b0, 0, 0, 2'b01);
        step(1'b0, 1'b0, 0, 0, 2'b11);
        run(3, 1'b0, 0, 0, 2'b00);

        // reset pulse during OPEN with trig held high across release
        step(1'b0, 1'b1, 0, 20, 2'b00);
        run(3, 1'b1, 0, 20, 2'b01);
        run(2, 1'b1, 0, 20, 2'b00);
        step(1'b1, 1'b1, 0, 20, 2'b00);
        run(5, 1'b1, 0, 20, 2'b00);
        run(30, 1'b0, 0, 0, 2'b00);

        // maximum width and maximum delay
        step(1'b0, 1'b1, 0, 255, 2'b00);
        run(280, 1'b0, 0, 255, 2'b00);
        step(1'b0, 1'b1, 255, 1, 2'b00);
        run(280, 1'b0, 255, 1, 2'b00);

        // randomized traffic
        t = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) t = ~t;
            d   = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(6));
            w   = ($urandom_range(4) == 0) ? 0 : int'($urandom_range(8));
            raw = ($urandom_range(5) == 0) ? NCH'($urandom) : '0;
            step(($urandom_range(399) == 0) ? 1'b1 : 1'b0, t, d, w, raw);
        end
        run(4, 1'b0, 0, 0, 2'b00);

        @(posedge clk);
        #5;
        if (sbq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
